// File: rtl/pe_mac_sequencer_if.sv
// Bundle of host-side and PE-side signals around pe_mac_sequencer.
//   master : host/PE environment (drives start, len, stream, res_ready, PE results)
//   slave  : the sequencer (drives s_ready, result, status and PE control)
//   start/len          job request, len is a vector length of 1..2**L_RAM_SIZE
//   s_data/s_valid/s_ready   operand stream (B words, then A words)
//   res_data/res_valid/res_ready   final FP32 result handshake
//   busy/err           status
//   pe_*               PE control/data
interface pe_mac_sequencer_if #(
  parameter int unsigned L_RAM_SIZE = 4
) ();
  logic                  start;
  logic [L_RAM_SIZE:0]   len;
  logic [31:0]           s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [31:0]           res_data;
  logic                  res_valid;
  logic                  res_ready;
  logic                  busy;
  logic                  err;
  logic                  pe_aresetn;
  logic [31:0]           pe_din;
  logic [L_RAM_SIZE-1:0] pe_addr;
  logic                  pe_we;
  logic [31:0]           pe_ain;
  logic                  pe_valid;
  logic                  pe_dvalid;
  logic [31:0]           pe_dout;

  modport master (
    output start, len, s_data, s_valid, res_ready, pe_dvalid, pe_dout,
    input  s_ready, res_data, res_valid, busy, err,
           pe_aresetn, pe_din, pe_addr, pe_we, pe_ain, pe_valid
  );

  modport slave (
    input  start, len, s_data, s_valid, res_ready, pe_dvalid, pe_dout,
    output s_ready, res_data, res_valid, busy, err,
           pe_aresetn, pe_din, pe_addr, pe_we, pe_ain, pe_valid
  );
endinterface

// File: rtl/pe_mac_sequencer.sv
// Drives one accumulating FP32 PE through a dot product: clear the PE, load
// B into PE RAM, issue one MAC per A word (waiting for each result), return
// the final accumulated value.
//   aclk, aresetn : clock, synchronous active-low reset
//   bus (slave)   : job request, operand stream, result handshake, status,
//                   and the PE control/data signals
module pe_mac_sequencer #(
  parameter int unsigned L_RAM_SIZE = 4,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic               aclk,
  input logic               aresetn,
  pe_mac_sequencer_if.slave bus
);
  localparam int unsigned LW      = L_RAM_SIZE + 1;
  localparam int unsigned MAX_LEN = 1 << L_RAM_SIZE;
  localparam int unsigned TMAX    = (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
  localparam int unsigned TW      = $clog2(TMAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_FETCH, S_ISSUE, S_WAIT, S_RESULT
  } state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  pe_aresetn_q, pe_aresetn_d;
  logic [31:0]           pe_din_q, pe_din_d;
  logic [L_RAM_SIZE-1:0] pe_addr_q, pe_addr_d;
  logic                  pe_we_q, pe_we_d;
  logic [31:0]           pe_ain_q, pe_ain_d;
  logic                  pe_valid_q, pe_valid_d;
  logic [31:0]           res_data_q, res_data_d;
  logic                  res_valid_q, res_valid_d;
  logic                  s_ready_c;
  logic                  last_c;

  // Stream is only accepted while loading B or issuing an A word.
  assign s_ready_c = (state_q == S_LOAD) || (state_q == S_ISSUE);
  assign last_c    = (cnt_q == len_q - LW'(1));

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      pe_aresetn_q <= 1'b0;
      pe_din_q     <= '0;
      pe_addr_q    <= '0;
      pe_we_q      <= 1'b0;
      pe_ain_q     <= '0;
      pe_valid_q   <= 1'b0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      pe_aresetn_q <= pe_aresetn_d;
      pe_din_q     <= pe_din_d;
      pe_addr_q    <= pe_addr_d;
      pe_we_q      <= pe_we_d;
      pe_ain_q     <= pe_ain_d;
      pe_valid_q   <= pe_valid_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    err_d      = 1'b0;
    pe_din_d   = pe_din_q;
    pe_addr_d  = pe_addr_q;
    pe_we_d    = 1'b0;
    pe_ain_d   = pe_ain_q;
    pe_valid_d = 1'b0;
    res_data_d = res_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if ((bus.len != '0) && (bus.len <= LW'(MAX_LEN))) begin
            len_d   = bus.len;
            cnt_d   = '0;
            tmr_d   = '0;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (tmr_q == TW'(CLR_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_LOAD;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_LOAD: begin
        if (bus.s_valid) begin
          pe_we_d   = 1'b1;
          pe_addr_d = cnt_q[L_RAM_SIZE-1:0];
          pe_din_d  = bus.s_data;
          if (last_c) begin
            cnt_d   = '0;
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end
      end
      // One idle cycle with the address presented so the PE RAM read settles.
      S_FETCH: begin
        pe_addr_d = cnt_q[L_RAM_SIZE-1:0];
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (bus.s_valid) begin
          pe_valid_d = 1'b1;
          pe_ain_d   = bus.s_data;
          tmr_d      = '0;
          state_d    = S_WAIT;
        end
      end
      // A dvalid in the final timer cycle still wins over the timeout.
      S_WAIT: begin
        if (bus.pe_dvalid) begin
          res_data_d = bus.pe_dout;
          cnt_d      = cnt_q + LW'(1);
          state_d    = last_c ? S_RESULT : S_FETCH;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_RESULT: begin
        if (bus.res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d       = (state_d != S_IDLE);
    res_valid_d  = (state_d == S_RESULT);
    pe_aresetn_d = (state_d != S_CLEAR);
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.res_data   = res_data_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.pe_aresetn = pe_aresetn_q;
  assign bus.pe_din     = pe_din_q;
  assign bus.pe_addr    = pe_addr_q;
  assign bus.pe_we      = pe_we_q;
  assign bus.pe_ain     = pe_ain_q;
  assign bus.pe_valid   = pe_valid_q;
endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Directed bench for pe_mac_sequencer with a behavioural accumulating FP32 PE.
module tb_pe_mac_sequencer;
  localparam int unsigned L      = 4;
  localparam int unsigned CLR    = 2;
  localparam int unsigned TMO    = 64;
  localparam int unsigned PE_LAT = 4;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  pe_mac_sequencer_if #(.L_RAM_SIZE(L)) bus ();

  pe_mac_sequencer #(.L_RAM_SIZE(L), .CLR_CYCLES(CLR), .TIMEOUT(TMO)) u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_miss = 0;
  logic [31:0] stim [$];
  int busy_low;
  int unstable;
  bit suppress = 1'b0;
  bit mon_clr = 1'b0;

  // FP32 <-> real for the small exact values used here.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  // Behavioural PE: RAM with registered read, accumulator fed back as addend.
  logic [31:0] ram [16];
  logic [31:0] rd_q;
  real acc_r, pend_r;
  int  cd;
  bit  pend;
  always @(posedge aclk) begin
    bus.pe_dvalid <= 1'b0;
    if (bus.pe_we) ram[bus.pe_addr] <= bus.pe_din;
    rd_q <= ram[bus.pe_addr];
    if (!bus.pe_aresetn) begin
      acc_r = 0.0; pend = 1'b0; cd = 0;
    end else if (bus.pe_valid) begin
      pend_r = acc_r + f2r(bus.pe_ain) * f2r(rd_q);
      pend = 1'b1; cd = PE_LAT;
    end else if (pend) begin
      cd = cd - 1;
      if (cd == 1) begin
        pend = 1'b0;
        if (!suppress) begin
          bus.pe_dvalid <= 1'b1;
          bus.pe_dout   <= r2f(pend_r);
          acc_r = pend_r;
        end
      end
    end
  end

  // Monitor on the falling edge.
  int cyc_n = 0, n_pv = 0, n_we = 0, n_err = 0, n_rv = 0;
  int addr_err = 0, exp_addr = 0, ovl = 0, pv_cyc = 0, err_cyc = 0;
  bit inflight = 1'b0, rv_prev = 1'b0;
  always @(negedge aclk) begin
    cyc_n++;
    if (mon_clr) begin
      n_pv = 0; n_we = 0; n_err = 0; n_rv = 0; addr_err = 0; exp_addr = 0;
      ovl = 0; pv_cyc = 0; err_cyc = 0; inflight = 1'b0;
    end else begin
      if (bus.pe_dvalid) inflight = 1'b0;
      if (bus.pe_valid) begin
        if (inflight) ovl++;
        inflight = 1'b1; n_pv++; pv_cyc = cyc_n;
      end
      if (bus.pe_we) begin
        if (bus.pe_addr !== 4'(exp_addr)) addr_err++;
        exp_addr++; n_we++;
      end
      if (bus.err) begin n_err++; err_cyc = cyc_n; end
      if (bus.res_valid && !rv_prev) n_rv++;
    end
    rv_prev = bus.res_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running required stopped");
    $fatal(1);
  end

  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1; step(); mon_clr = 1'b0;
    busy_low = 0; unstable = 0;
  endtask

  task automatic load_dot3();
    stim = '{32'h3F800000, 32'h40000000, 32'h40400000,
             32'h40800000, 32'h40A00000, 32'h40C00000};
  endtask

  task automatic send_words(input bit toggle);
    int idx, cyc;
    bit hs;
    idx = 0; cyc = 0;
    while (idx < stim.size() && cyc < 1000) begin
      bus.s_valid = !(toggle && (cyc % 2 == 1));
      bus.s_data  = stim[idx];
      hs = bus.s_valid && bus.s_ready;
      step(); cyc++;
      if (!bus.busy) busy_low++;
      if (hs) idx++;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic run_job(input int n, input bit toggle, input int hold,
                         output logic [31:0] res, output bit got);
    int cyc;
    bus.start = 1'b1; bus.len = 5'(n); step(); bus.start = 1'b0;
    send_words(toggle);
    cyc = 0;
    while (!bus.res_valid && cyc < 1000) begin
      step(); cyc++;
      if (!bus.busy) busy_low++;
    end
    got = bus.res_valid; res = bus.res_data;
    for (int i = 0; i < hold; i++) begin
      step();
      if (bus.res_data !== res || !bus.res_valid) unstable++;
      if (!bus.busy) busy_low++;
    end
    if (got) begin bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0; end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; step(); step();
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.pe_aresetn !== 1'b0) begin n_miss++; $display("FAIL reset_pe_aresetn got %b want 0", bus.pe_aresetn); end
    n_vec++; if ({bus.res_valid, bus.err, bus.pe_we, bus.pe_valid, bus.s_ready} !== 5'b0) begin
      n_miss++; $display("FAIL reset_outs got %b want 00000", {bus.res_valid, bus.err, bus.pe_we, bus.pe_valid, bus.s_ready}); end
    n_vec++; if (bus.res_data !== 32'h0) begin n_miss++; $display("FAIL reset_res_data got %h want 0", bus.res_data); end
    aresetn = 1'b1; step();
    n_vec++; if (bus.pe_aresetn !== 1'b1) begin n_miss++; $display("FAIL idle_pe_aresetn got %b want 1", bus.pe_aresetn); end
  endtask

  task automatic test_dot3();
    logic [31:0] r; bit got;
    clr_mon(); load_dot3();
    run_job(3, 1'b0, 0, r, got); step();
    n_vec++; if (!got || r !== 32'h42000000) begin n_miss++; $display("FAIL dot3_result got %h (valid %b) want 42000000", r, got); end
    n_vec++; if (n_pv !== 3) begin n_miss++; $display("FAIL dot3_pe_valid_count got %0d want 3", n_pv); end
    n_vec++; if (ovl !== 0) begin n_miss++; $display("FAIL dot3_overlap got %0d want 0", ovl); end
    n_vec++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_miss++; $display("FAIL dot3_done got res_valid %b busy %b want 0 0", bus.res_valid, bus.busy); end
  endtask

  task automatic test_len16();
    logic [31:0] r; bit got;
    clr_mon(); stim = {};
    for (int i = 0; i < 32; i++) stim.push_back(32'h3F800000);
    run_job(16, 1'b0, 0, r, got); step();
    n_vec++; if (!got || r !== 32'h41800000) begin n_miss++; $display("FAIL len16_result got %h (valid %b) want 41800000", r, got); end
    n_vec++; if (n_we !== 16 || addr_err !== 0) begin
      n_miss++; $display("FAIL len16_addr got %0d writes %0d out-of-order want 16 0", n_we, addr_err); end
    n_vec++; if (n_pv !== 16) begin n_miss++; $display("FAIL len16_pe_valid_count got %0d want 16", n_pv); end
  endtask

  task automatic test_illegal_len();
    clr_mon();
    bus.start = 1'b1; bus.len = 5'd0; step(); bus.start = 1'b0;
    n_vec++; if (bus.err !== 1'b1) begin n_miss++; $display("FAIL len0_err got %b want 1", bus.err); end
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL len0_busy got %b want 0", bus.busy); end
    step();
    n_vec++; if (bus.err !== 1'b0) begin n_miss++; $display("FAIL len0_err_pulse got %b want 0", bus.err); end
    bus.start = 1'b1; bus.len = 5'd17; step(); bus.start = 1'b0;
    n_vec++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      n_miss++; $display("FAIL len17 got err %b busy %b want 1 0", bus.err, bus.busy); end
    step(); step();
    n_vec++; if (n_err !== 2 || n_we !== 0) begin n_miss++; $display("FAIL illegal_counts got err %0d we %0d want 2 0", n_err, n_we); end
  endtask

  task automatic test_stall();
    logic [31:0] r; bit got;
    clr_mon(); load_dot3();
    run_job(3, 1'b1, 10, r, got); step();
    n_vec++; if (!got || r !== 32'h42000000) begin n_miss++; $display("FAIL stall_result got %h (valid %b) want 42000000", r, got); end
    n_vec++; if (unstable !== 0) begin n_miss++; $display("FAIL stall_res_stable got %0d changes want 0", unstable); end
    n_vec++; if (busy_low !== 0) begin n_miss++; $display("FAIL stall_busy got %0d low cycles want 0", busy_low); end
    n_vec++; if (n_rv !== 1) begin n_miss++; $display("FAIL stall_res_valid_pulses got %0d want 1", n_rv); end
  endtask

  task automatic test_timeout();
    int k;
    clr_mon(); load_dot3();
    void'(stim.pop_back()); void'(stim.pop_back());
    suppress = 1'b1;
    bus.start = 1'b1; bus.len = 5'd3; step(); bus.start = 1'b0;
    send_words(1'b0);
    k = 0;
    while (!bus.err && k < 300) begin step(); k++; end
    step();
    n_vec++; if (n_err !== 1) begin n_miss++; $display("FAIL timeout_err_count got %0d want 1", n_err); end
    n_vec++; if (err_cyc - pv_cyc !== TMO) begin
      n_miss++; $display("FAIL timeout_latency got %0d want %0d", err_cyc - pv_cyc, TMO); end
    n_vec++; if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin
      n_miss++; $display("FAIL timeout_idle got busy %b s_ready %b want 0 0", bus.busy, bus.s_ready); end
    n_vec++; if (n_rv !== 0 || n_pv !== 1) begin
      n_miss++; $display("FAIL timeout_no_result got res_valid %0d pe_valid %0d want 0 1", n_rv, n_pv); end
    suppress = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; bit g1, g2;
    clr_mon(); load_dot3();
    void'(stim.pop_back()); void'(stim.pop_back()); void'(stim.pop_back());
    bus.start = 1'b1; bus.len = 5'd3; step(); bus.start = 1'b0;
    send_words(1'b0); step();
    n_vec++; if (bus.s_ready !== 1'b1) begin n_miss++; $display("FAIL abort_in_issue got s_ready %b want 1", bus.s_ready); end
    aresetn = 1'b0; step();
    n_vec++; if (bus.busy !== 1'b0 || bus.pe_aresetn !== 1'b0) begin
      n_miss++; $display("FAIL abort_reset got busy %b pe_aresetn %b want 0 0", bus.busy, bus.pe_aresetn); end
    aresetn = 1'b1; step();
    clr_mon(); load_dot3();
    run_job(3, 1'b0, 0, r1, g1);
    run_job(3, 1'b0, 0, r2, g2);
    n_vec++; if (!g1 || r1 !== 32'h42000000) begin n_miss++; $display("FAIL b2b_first got %h (valid %b) want 42000000", r1, g1); end
    n_vec++; if (!g2 || r2 !== 32'h42000000) begin n_miss++; $display("FAIL b2b_second got %h (valid %b) want 42000000", r2, g2); end
  endtask

  initial begin
    aresetn = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.s_data = '0; bus.s_valid = 1'b0; bus.res_ready = 1'b0;
    test_reset();
    test_dot3();
    test_len16();
    test_illegal_len();
    test_stall();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
